cond_flags_stage: RTL
=====================

Name: cond_flags_stage

Overview:
- Execute-stage back end, directly downstream of the 32-bit ALU.
- Holds the architectural NZCV flag register and evaluates the ARM condition field of the instruction in execute against those flags.
- Conditionally commits new flags from the ALU, then registers the ALU result, destination and write-enable into the EX/MEM pipeline register.
- Uses a valid/ready handshake on both sides.

Parameters:
FULLW, 32, datapath width of ALU result
FLAGSW, 4, flag vector width; bit 0 Z, 1 C, 2 N, 3 V (ALU flag ordering)
REGAW, 4, register address width

Ports:
clk  input  1  clock; all state updates on rising edge
nrst  input  1  synchronous reset, active-low
valid_in  input  1  execute-stage instruction valid
ready_out  output  1  stage can accept this cycle
cond  input  4  ARM condition field of the instruction
setflags  input  1  S bit; commit alu_flags if the instruction executes
alu_out  input  FULLW  ALU result
alu_flags  input  FLAGSW  ALU flag vector {V,N,C,Z}
rd_in  input  REGAW  destination register
wr_en_in  input  1  instruction intends a register write
flush  input  1  kill the instruction in execute and empty the output register
flags_wr  input  1  direct flag write (MSR-style)
flags_wdata  input  FLAGSW  direct flag write data
flags  output  FLAGSW  current committed flag register
valid_out  output  1  EX/MEM register holds an instruction
ready_in  input  1  downstream accepts
result_out  output  FULLW  registered ALU result
rd_out  output  REGAW  registered destination
wr_en_out  output  1  registered wr_en_in & pass
executed_out  output  1  registered condition-pass bit

Behaviour:
- Reset (nrst=0 at edge): flags=0, valid_out=0, result_out=0, rd_out=0, wr_en_out=0, executed_out=0. Reset overrides all other inputs, including a mid-handshake transfer.
- Condition evaluation is combinational against the registered flags, never against alu_flags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 (NV): 0
- Output register is a two-state FSM:
  - EMPTY (valid_out=0), FULL (valid_out=1).
  - ready_out = ~valid_out | ready_in. Purely combinational; does not depend on valid_in.
  - accept = valid_in & ready_out & ~flush.
- On accept:
  - valid_out<=1.
  - result_out<=alu_out, rd_out<=rd_in.
  - executed_out<=pass, wr_en_out<=wr_en_in&pass.
  - A non-executed instruction still occupies a slot with wr_en_out=0.
- FULL & ready_in & ~accept: valid_out<=0. Data outputs hold their values.
- FULL & ~ready_in: all outputs hold; no accept.
- Flag update priority, highest first:
  - reset
  - flags_wr: flags<=flags_wdata
  - accept & pass & setflags: flags<=alu_flags
  - otherwise hold.
- Flags update in the same edge as accept. A dependent instruction presented the next cycle sees the new flags; there is no bypass.
- flush=1:
  - No accept and no flag update from the execute instruction.
  - valid_out<=0, even if FULL & ~ready_in.
  - flags_wr still honoured.
- Stalled instruction (valid_in & ~ready_out): no flag update; re-evaluated each cycle until accepted.
- Throughput: 1 instruction/cycle when ready_in=1. Latency: 1 cycle from accept to valid_out.

Test Plan:
- Reset/basic: hold nrst=0 two cycles -> all outputs 0. Then valid_in=1, cond=1110, setflags=1, alu_out=0, alu_flags=4'b0001, rd_in=3, wr_en_in=1 -> next cycle valid_out=1, result_out=0, rd_out=3, wr_en_out=1, executed_out=1, flags=4'b0001.
- Condition fail: flags Z=1; issue cond=0001 (NE), setflags=1, alu_flags=4'b0100 -> executed_out=0, wr_en_out=0, valid_out=1, flags remains 4'b0001.
- Sweep: for each of the 16 flag values × 16 cond codes -> executed_out matches the table. NV is always 0; AL is always 1.
- Back-pressure: FULL with ready_in=0 for 3 cycles while valid_in=1, setflags=1 -> ready_out=0, outputs and flags unchanged. Raise ready_in -> instruction accepted next edge, flags update once.
- Flush/priority: flush=1 with valid_in=1, setflags=1, FULL, ready_in=0 -> valid_out=0 next cycle, flags unchanged. Same cycle flags_wr=1, flags_wdata=4'b1010 -> flags=4'b1010.
- Reset mid-stream: nrst=0 while FULL and accepting -> valid_out=0, flags=0 on that edge.

Source files
------------

// File: rtl/cond_flags_stage.sv
// Execute-stage back end: NZCV flag register, ARM condition evaluation against the
// committed flags, and the valid/ready EX/MEM output register.
module cond_flags_stage #(
  parameter int FULLW  = 32,
  parameter int FLAGSW = 4,
  parameter int REGAW  = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [3:0]        cond,
  input  logic              setflags,
  input  logic [FULLW-1:0]  alu_out,
  input  logic [FLAGSW-1:0] alu_flags,
  input  logic [REGAW-1:0]  rd_in,
  input  logic              wr_en_in,
  input  logic              flush,
  input  logic              flags_wr,
  input  logic [FLAGSW-1:0] flags_wdata,
  output logic [FLAGSW-1:0] flags,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [FULLW-1:0]  result_out,
  output logic [REGAW-1:0]  rd_out,
  output logic              wr_en_out,
  output logic              executed_out
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e             state_q, state_d;
  logic [FLAGSW-1:0]  flags_q, flags_d;
  logic [FULLW-1:0]   result_q, result_d;
  logic [REGAW-1:0]   rd_q, rd_d;
  logic               wr_en_q, wr_en_d;
  logic               exec_q, exec_d;

  logic flag_z, flag_c, flag_n, flag_v;
  logic pass, accept;

  // ALU flag ordering: bit0 Z, bit1 C, bit2 N, bit3 V
  assign flag_z = flags_q[0];
  assign flag_c = flags_q[1];
  assign flag_n = flags_q[2];
  assign flag_v = flags_q[3];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      4'b0000: pass = flag_z;
      4'b0001: pass = ~flag_z;
      4'b0010: pass = flag_c;
      4'b0011: pass = ~flag_c;
      4'b0100: pass = flag_n;
      4'b0101: pass = ~flag_n;
      4'b0110: pass = flag_v;
      4'b0111: pass = ~flag_v;
      4'b1000: pass = flag_c & ~flag_z;
      4'b1001: pass = ~flag_c | flag_z;
      4'b1010: pass = (flag_n == flag_v);
      4'b1011: pass = (flag_n != flag_v);
      4'b1100: pass = ~flag_z & (flag_n == flag_v);
      4'b1101: pass = flag_z | (flag_n != flag_v);
      4'b1110: pass = 1'b1;
      4'b1111: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

  assign valid_out = (state_q == FULL);
  assign ready_out = ~valid_out | ready_in;
  assign accept    = valid_in & ready_out & ~flush;

  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    result_d = result_q;
    rd_d     = rd_q;
    wr_en_d  = wr_en_q;
    exec_d   = exec_q;

    if (accept) begin
      state_d  = FULL;
      result_d = alu_out;
      rd_d     = rd_in;
      wr_en_d  = wr_en_in & pass;
      exec_d   = pass;
    end else if (flush) begin
      state_d = EMPTY;
    end else if (state_q == FULL && ready_in) begin
      state_d = EMPTY;
    end

    if (flags_wr) begin
      flags_d = flags_wdata;
    end else if (accept && pass && setflags) begin
      flags_d = alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= EMPTY;
      flags_q  <= '0;
      result_q <= '0;
      rd_q     <= '0;
      wr_en_q  <= 1'b0;
      exec_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wr_en_q  <= wr_en_d;
      exec_q   <= exec_d;
    end
  end

  assign flags        = flags_q;
  assign result_out   = result_q;
  assign rd_out       = rd_q;
  assign wr_en_out    = wr_en_q;
  assign executed_out = exec_q;

endmodule
